regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/regwb_pkg.sv | 18 +
 rtl/regwb_slot.sv | 32 +++
 rtl/regwb_arbiter.sv | 96 +++++++++
 tb/tb_regwb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/regwb_pkg.sv
// Shared widths, source identifiers and the holding-slot record for the writeback arbiter.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package regwb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic SRC_ALU = 1'b0;
  localparam logic SRC_MEM = 1'b1;

  // age = 1 marks the slot holding the older of two pending writes
  typedef struct packed {
    logic              valid;
    logic              age;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } slot_t;
endpackage

// File: rtl/regwb_slot.sv
// One-entry holding register for a single writeback source, with valid and age bits.
// Latency: a load is visible on slot at the next clk edge.
// Backpressure: rdy = empty or draining this cycle; never depends on the request.
module regwb_slot
  import regwb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              ageIn,
  input  logic [ADDR_W-1:0] loadAddr,
  input  logic [DATA_W-1:0] loadData,
  input  logic              issue,
  output slot_t             slot,
  output logic              rdy
);

  assign rdy = !slot.valid | issue;

  // Load wins over drain; an entry that survives a cycle unissued has become the older one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot <= '0;
    end else if (load) begin
      slot <= '{valid: 1'b1, age: ageIn, addr: loadAddr, data: loadData};
    end else begin
      slot.valid <= slot.valid & !issue;
      slot.age   <= slot.valid & !issue;
    end
  end

endmodule

// File: rtl/regwb_arbiter.sv
// Merges ALU and load writebacks onto the single register-file write port.
// Latency: accept at edge N, regWriteEn high after edge N+1 when uncontended.
// Backpressure: per-source rdy drops only while that source's slot is full and not selected.
module regwb_arbiter #(
  parameter int DATA_W = regwb_pkg::DATA_W,
  parameter int ADDR_W = regwb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_req,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_rdy,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_rdy,
  output logic              regWriteEn,
  output logic [ADDR_W-1:0] regWriteAddr,
  output logic [DATA_W-1:0] regWriteData,
  input  logic [ADDR_W-1:0] q_addr,
  output logic              q_hit
);
  import regwb_pkg::*;

  slot_t aluSlot, memSlot;
  logic  aluLoad, memLoad, aluIssue, memIssue, aluStay, memStay;
  logic  aluAgeIn, memAgeIn, bothValid, anyValid, selSrc, pickBoth, rrPtr;

  // Writes to r0 are consumed at the handshake but never occupy a slot
  assign aluLoad = alu_req & alu_rdy & (alu_addr != '0);
  assign memLoad = mem_req & mem_rdy & (mem_addr != '0);

  assign aluStay = aluSlot.valid & !aluIssue;
  assign memStay = memSlot.valid & !memIssue;

  // A new entry is younger than one left behind; same-cycle loads make ALU the older
  assign aluAgeIn = !memStay;
  assign memAgeIn = !aluStay & !aluLoad;

  regwb_slot uAluSlot (
    .clk(clk), .reset(reset), .load(aluLoad), .ageIn(aluAgeIn),
    .loadAddr(alu_addr), .loadData(alu_data), .issue(aluIssue),
    .slot(aluSlot), .rdy(alu_rdy)
  );

  regwb_slot uMemSlot (
    .clk(clk), .reset(reset), .load(memLoad), .ageIn(memAgeIn),
    .loadAddr(mem_addr), .loadData(mem_data), .issue(memIssue),
    .slot(memSlot), .rdy(mem_rdy)
  );

  assign bothValid = aluSlot.valid & memSlot.valid;
  assign anyValid  = aluSlot.valid | memSlot.valid;

  // Same destination pending twice: the older must go first so the younger value lands last
  assign pickBoth = ((aluSlot.addr == memSlot.addr) && (aluSlot.age != memSlot.age))
                    ? (aluSlot.age ? SRC_ALU : SRC_MEM) : rrPtr;

  // Choose the source to issue this cycle
  always_comb begin
    selSrc = SRC_ALU;
    if (bothValid)          selSrc = pickBoth;
    else if (memSlot.valid) selSrc = SRC_MEM;
  end

  assign aluIssue = aluSlot.valid & (selSrc == SRC_ALU);
  assign memIssue = memSlot.valid & (selSrc == SRC_MEM);

  // Round-robin pointer moves only on a contended pick, toward the loser
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         rrPtr <= SRC_ALU;
    else if (bothValid) rrPtr <= (selSrc == SRC_ALU) ? SRC_MEM : SRC_ALU;
  end

  // Registered write port; address/data hold their last value while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      regWriteEn   <= 1'b0;
      regWriteAddr <= '0;
      regWriteData <= '0;
    end else begin
      regWriteEn <= anyValid;
      if (anyValid) begin
        regWriteAddr <= (selSrc == SRC_MEM) ? memSlot.addr : aluSlot.addr;
        regWriteData <= (selSrc == SRC_MEM) ? memSlot.data : aluSlot.data;
      end
    end
  end

  assign q_hit = (q_addr != '0) &
                 ((aluSlot.valid & (aluSlot.addr == q_addr)) |
                  (memSlot.valid & (memSlot.addr == q_addr)) |
                  (regWriteEn & (regWriteAddr == q_addr)));

endmodule

// File: tb/tb_regwb_arbiter.sv
module tb_regwb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_req, mem_req;
  logic [4:0]  alu_addr, mem_addr, q_addr;
  logic [31:0] alu_data, mem_data;
  logic        alu_rdy, mem_rdy, regWriteEn, q_hit;
  logic [4:0]  regWriteAddr;
  logic [31:0] regWriteData;

  int vectors = 0;
  int miscompares = 0;

  logic [36:0] aluQ[$];
  logic [36:0] memQ[$];
  logic [31:0] rf[32];

  regwb_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .alu_req(alu_req), .alu_addr(alu_addr), .alu_data(alu_data), .alu_rdy(alu_rdy),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_rdy(mem_rdy),
    .regWriteEn(regWriteEn), .regWriteAddr(regWriteAddr), .regWriteData(regWriteData),
    .q_addr(q_addr), .q_hit(q_hit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: record accepts and register-file writes before the edge, check issued write after it
  task automatic tick();
    logic [36:0] got;
    logic        hit;
    if (regWriteEn && regWriteAddr != 5'd0) rf[regWriteAddr] = regWriteData;
    if (reset && alu_req && alu_rdy && alu_addr != 5'd0) aluQ.push_back({alu_addr, alu_data});
    if (reset && mem_req && mem_rdy && mem_addr != 5'd0) memQ.push_back({mem_addr, mem_data});
    @(posedge clk);
    #1;
    if (regWriteEn) begin
      got = {regWriteAddr, regWriteData};
      hit = 1'b0;
      if (aluQ.size() > 0 && aluQ[0] === got) begin
        void'(aluQ.pop_front());
        hit = 1'b1;
      end else if (memQ.size() > 0 && memQ[0] === got) begin
        void'(memQ.pop_front());
        hit = 1'b1;
      end
      vectors++;
      assert (hit === 1'b1) else begin
        miscompares++;
        $error("FAIL sb_write: observed addr %0d data %0h, expected a pending write at a queue head",
               regWriteAddr, regWriteData);
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && (aluQ.size() + memQ.size()) > 0; k++) tick();
    tick();
    chk("drain_empty", 64'(aluQ.size() + memQ.size()), 64'd0);
  endtask

  task automatic idle();
    alu_req = 1'b0;
    mem_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic prevAlu, lastSrc, src;
    int   wr;
    for (int r = 0; r < 32; r++) rf[r] = 32'd0;
    reset = 1'b0;
    alu_req = 1'b0; mem_req = 1'b0;
    alu_addr = 5'd0; mem_addr = 5'd0; alu_data = 32'd0; mem_data = 32'd0;
    q_addr = 5'd5;
    #1;
    chk("rst_en",   64'(regWriteEn),   64'd0);
    chk("rst_addr", 64'(regWriteAddr), 64'd0);
    chk("rst_data", 64'(regWriteData), 64'd0);
    chk("rst_alu_rdy", 64'(alu_rdy), 64'd1);
    chk("rst_mem_rdy", 64'(mem_rdy), 64'd1);
    chk("rst_qhit", 64'(q_hit), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("post_rst_en", 64'(regWriteEn), 64'd0);

    // single ALU write, two-cycle latency
    alu_req = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234;
    tick();
    idle();
    chk("lat_n1_en", 64'(regWriteEn), 64'd0);
    tick();
    chk("lat_n2_en",   64'(regWriteEn),   64'd1);
    chk("lat_n2_addr", 64'(regWriteAddr), 64'd5);
    chk("lat_n2_data", 64'(regWriteData), 64'h1234);
    tick();
    chk("lat_idle_en", 64'(regWriteEn), 64'd0);
    chk("rf5", 64'(rf[5]), 64'h1234);

    // contention: ALU first from reset, MEM next
    alu_req = 1'b1; alu_addr = 5'd3; alu_data = 32'hA3;
    mem_req = 1'b1; mem_addr = 5'd7; mem_data = 32'hB7;
    tick();
    idle();
    tick();
    chk("cont1_first", 64'(regWriteAddr), 64'd3);
    tick();
    chk("cont1_second_en", 64'(regWriteEn),   64'd1);
    chk("cont1_second",    64'(regWriteAddr), 64'd7);
    tick();
    chk("rf3", 64'(rf[3]), 64'hA3);
    chk("rf7", 64'(rf[7]), 64'hB7);

    // next contention favours MEM
    alu_req = 1'b1; alu_addr = 5'd10; alu_data = 32'h10;
    mem_req = 1'b1; mem_addr = 5'd11; mem_data = 32'h11;
    tick();
    idle();
    tick();
    chk("cont2_first", 64'(regWriteAddr), 64'd11);
    tick();
    chk("cont2_second", 64'(regWriteAddr), 64'd10);

    // then ALU again, leaving the pointer favouring MEM
    alu_req = 1'b1; alu_addr = 5'd13; alu_data = 32'h13;
    mem_req = 1'b1; mem_addr = 5'd14; mem_data = 32'h14;
    tick();
    idle();
    tick();
    chk("cont3_first", 64'(regWriteAddr), 64'd13);
    tick();
    chk("cont3_second", 64'(regWriteAddr), 64'd14);

    // same destination: age overrides round-robin, MEM value is final
    alu_req = 1'b1; alu_addr = 5'd9; alu_data = 32'd1;
    mem_req = 1'b1; mem_addr = 5'd9; mem_data = 32'd2;
    tick();
    idle();
    tick();
    chk("same_first_data", 64'(regWriteData), 64'd1);
    tick();
    chk("same_second_data", 64'(regWriteData), 64'd2);
    tick();
    chk("rf9", 64'(rf[9]), 64'd2);

    // write to r0 is swallowed
    mem_req = 1'b1; mem_addr = 5'd0; mem_data = 32'hFFFF;
    chk("r0_mem_rdy", 64'(mem_rdy), 64'd1);
    tick();
    idle();
    chk("r0_en_a", 64'(regWriteEn), 64'd0);
    tick();
    chk("r0_en_b", 64'(regWriteEn), 64'd0);
    drain();

    // both sources every cycle
    wr = 0; prevAlu = 1'b0; lastSrc = 1'b0;
    for (int i = 0; i < 21; i++) begin
      alu_req = 1'b1; alu_addr = 5'(1 + i % 15);  alu_data = $urandom;
      mem_req = 1'b1; mem_addr = 5'(16 + i % 15); mem_data = $urandom;
      if (i == 0) chk("stream_rdy_both", 64'(alu_rdy & mem_rdy), 64'd1);
      if (i == 1) chk("stream_rdy_split", 64'(alu_rdy ^ mem_rdy), 64'd1);
      if (i >= 2) chk("stream_rdy_toggle", 64'(alu_rdy), 64'(!prevAlu));
      prevAlu = alu_rdy;
      tick();
      if (regWriteEn) begin
        wr++;
        src = regWriteAddr[4];
        if (wr > 1) chk("stream_alternate", 64'(src), 64'(!lastSrc));
        lastSrc = src;
      end
    end
    chk("stream_count", 64'(wr), 64'd20);
    idle();
    drain();

    // hazard query and reset with slots full
    alu_req = 1'b1; alu_addr = 5'd12; alu_data = 32'hC0C0;
    mem_req = 1'b1; mem_addr = 5'd20; mem_data = 32'hD0D0;
    tick();
    idle();
    q_addr = 5'd12; #1;
    chk("qhit_12", 64'(q_hit), 64'd1);
    q_addr = 5'd21; #1;
    chk("qhit_21", 64'(q_hit), 64'd0);
    tick();
    chk("prerst_en", 64'(regWriteEn), 64'd1);
    q_addr = 5'd20; #1;
    chk("qhit_20", 64'(q_hit), 64'd1);
    reset = 1'b0; #1;
    chk("arst_qhit", 64'(q_hit), 64'd0);
    chk("arst_en", 64'(regWriteEn), 64'd0);
    chk("arst_alu_rdy", 64'(alu_rdy), 64'd1);
    chk("arst_mem_rdy", 64'(mem_rdy), 64'd1);
    aluQ.delete();
    memQ.delete();
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("after_rst_en", 64'(regWriteEn), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
